opv_gain_sweep_ctrl: RTL and testbench
======================================

Name: opv_gain_sweep_ctrl

Overview:
- Digital stimulus/measurement controller for the single op-amp DC/AC gain test bench; it is the driving end of the bias current source and the reading end of the amplifier output.
- Steps a bias DAC code across a programmed sweep and waits a fixed settling time at each point.
- Reads the op-amp output through an ADC request/valid handshake.
- Streams the point-to-point output delta (incremental gain numerator) over a valid/ready result interface.

Parameters:
- DAC_W, 8, width of bias DAC code, step and point count
- ADC_W, 12, width of unsigned ADC sample
- SETTLE_CYC, 16, cycles to wait after each DAC load before sampling (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  sweep start pulse; sampled only in IDLE
- cfg_start  in  DAC_W  first DAC code
- cfg_step  in  DAC_W  unsigned code increment per point
- cfg_npts  in  DAC_W  number of sweep points
- dac_code  out  DAC_W  current bias code
- dac_load  out  1  one-cycle strobe, dac_code valid
- adc_req  out  1  sample request, held until adc_valid
- adc_valid  in  1  sample ready
- adc_data  in  ADC_W  sample value
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  ADC_W+1  signed delta = sample[i] - sample[i-1]
- res_idx  out  DAC_W  point index i of result (1..npts-1)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of sweep
- err  out  1  sticky error flag; cleared by next accepted start

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal counters, prev sample and config latch cleared. Asserting rst_n low mid-sweep aborts immediately, with no done pulse.
- start in IDLE latches cfg_*, clears err and sets i=0. start while busy is ignored.
- cfg_npts<2: go straight to DONE, err=1, no DAC load, no results.
- States: IDLE -> LOAD -> SETTLE -> SAMPLE -> (EMIT) -> LOAD | DONE -> IDLE.
- LOAD (1 cycle):
  - dac_code = cfg_start + i*cfg_step, computed in DAC_W+1 bits by running accumulation, not a multiplier.
  - If bit DAC_W is set (code overflow): no dac_load, err=1, go to DONE.
  - Otherwise dac_load=1 for this cycle only; dac_code holds its value until the next LOAD.
- SETTLE: counts SETTLE_CYC cycles, then goes to SAMPLE. The first adc_req asserts exactly 1+SETTLE_CYC cycles after the LOAD cycle begins.
- SAMPLE:
  - adc_req is high from state entry until the cycle adc_valid=1. adc_data is captured that cycle, and adc_req drops the next cycle.
  - adc_valid while adc_req is low is ignored.
  - i=0: store sample as prev, i=1, go to LOAD; no result.
  - i>=1: res_data = zero-extended(cur) - zero-extended(prev), two's complement, ADC_W+1 bits, never saturating. res_idx=i, prev=cur, go to EMIT.
- EMIT:
  - res_valid=1, with res_data/res_idx stable until the cycle res_valid&&res_ready. Back-pressure is unbounded.
  - On transfer: res_valid drops the next cycle and i increments.
  - If i+1==cfg_npts, go to DONE; else go to LOAD.
- DONE (1 cycle): done=1, busy=1, then IDLE. busy drops in the same cycle IDLE is entered.
- res_valid is never asserted outside EMIT. A new start is accepted no earlier than the cycle after done.

Decomposition:
- Shared package opv_meas_pkg holds:
  - state enum typedef (IDLE, LOAD, SETTLE, SAMPLE, EMIT, DONE)
  - default widths DAC_W/ADC_W
  - result struct {idx, delta}
- One natural sub-module: opv_settle_timer (loadable down-counter with expire pulse), used by SETTLE.
- Everything else is in a single FSM module.

Test Plan:
- start=5, step=10, npts=4, SETTLE_CYC=16; ADC returns 100,150,140,4095 -> dac_load codes 5,15,25,35; results (1,+50),(2,-10),(3,+3955); one done pulse; err=0.
- Timing check with SETTLE_CYC=16, adc_valid given 3 cycles after adc_req -> adc_req rises 17 cycles after dac_load, drops the cycle after adc_valid; first-point-to-result latency matches.
- res_ready held low 20 cycles during EMIT -> res_valid, res_data and res_idx stable throughout; no further dac_load until the transfer completes.
- start=250, step=3, npts=4 -> loads 250,253; third LOAD overflows -> err=1, done pulse, only result idx 1 emitted, dac_code stays 253.
- npts=1 -> done pulse 2 cycles after start, err=1, no dac_load; next start with npts=2 clears err and emits one result.
- rst_n pulsed low during SETTLE of point 2 -> all outputs 0 asynchronously, no done pulse; start after release runs a fresh sweep from i=0; start pulses during busy are ignored.

Source files
------------

// File: rtl/opv_meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opv_meas_pkg
// Description : Shared types and default widths for the op-amp gain sweep
//               controller: FSM state encoding, default DAC/ADC widths and
//               the result record {idx, delta}.
// Revision    : 1.0 - initial release
// ============================================================================
package opv_meas_pkg;

  // Default widths of the bias DAC code and the unsigned ADC sample
  localparam int c_DAC_W = 8;
  localparam int c_ADC_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_EMIT   = 3'd4,
    ST_DONE   = 3'd5
  } opv_state_t;

  // One streamed result: point index and signed sample delta
  typedef struct packed {
    logic [c_DAC_W-1:0] idx;
    logic [c_ADC_W:0]   delta;
  } opv_result_t;

endpackage
`default_nettype wire

// File: rtl/opv_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : opv_settle_timer
// Description : Loadable down-counter. After a load with value N, expire is
//               high during the (N+1)-th following cycle, then the timer
//               idles until the next load.
// Ports       : clk, rst_n        - clock, async active-low reset
//               load, load_val    - (re)start the count at load_val
//               expire            - one-cycle pulse when the count ends
// Revision    : 1.0 - initial release
// ============================================================================
module opv_settle_timer
  import opv_meas_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (load) begin
      r_cnt <= load_val;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign expire = r_run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/opv_gain_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : opv_gain_sweep_ctrl
// Description : Op-amp gain sweep controller. Steps a bias DAC code across a
//               programmed sweep, waits SETTLE_CYC cycles per point, samples
//               the amplifier output through an ADC req/valid handshake and
//               streams the point-to-point delta over a valid/ready port.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               start, cfg_start/step/npts    - sweep launch and setup
//               dac_code, dac_load            - bias DAC code and load strobe
//               adc_req, adc_valid, adc_data  - ADC sample handshake
//               res_valid, res_ready,
//               res_data, res_idx             - result stream
//               busy, done, err               - status
// Revision    : 1.0 - initial release
// ============================================================================
module opv_gain_sweep_ctrl
  import opv_meas_pkg::*;
#(
  parameter int DAC_W      = c_DAC_W,
  parameter int ADC_W      = c_ADC_W,
  parameter int SETTLE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DAC_W-1:0] cfg_start,
  input  logic [DAC_W-1:0] cfg_step,
  input  logic [DAC_W-1:0] cfg_npts,
  output logic [DAC_W-1:0] dac_code,
  output logic             dac_load,
  output logic             adc_req,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ADC_W:0]   res_data,
  output logic [DAC_W-1:0] res_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int                 c_CNT_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_SETTLE_LD = c_CNT_W'(SETTLE_CYC - 1);

  opv_state_t       r_state;
  logic [DAC_W:0]   r_acc;      // code of the current point, one carry bit
  logic [DAC_W-1:0] r_step;
  logic [DAC_W-1:0] r_npts;
  logic [DAC_W-1:0] r_idx;
  logic [ADC_W-1:0] r_prev;

  logic [DAC_W-1:0] r_dac_code;
  logic             r_dac_load;
  logic             r_adc_req;
  logic             r_res_valid;
  logic [ADC_W:0]   r_res_data;
  logic [DAC_W-1:0] r_res_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [DAC_W:0]   w_acc_next;
  logic             w_ovf;
  logic [DAC_W:0]   w_idx_p1;
  logic [ADC_W:0]   w_delta;
  logic             w_settle_exp;

  // Running accumulation of the sweep code; the carry bit flags overflow
  assign w_acc_next = r_acc + {1'b0, r_step};
  assign w_ovf      = w_acc_next[DAC_W];
  assign w_idx_p1   = {1'b0, r_idx} + (DAC_W + 1)'(1);
  assign w_delta    = {1'b0, adc_data} - {1'b0, r_prev};

  opv_settle_timer #(
    .CNT_W (c_CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (r_state == ST_LOAD),
    .load_val (c_SETTLE_LD),
    .expire   (w_settle_exp)
  );

  // dac_load is registered so that it is high during the LOAD state cycle:
  // the next code and its overflow are resolved on the transition into LOAD.
  // A sweep with fewer than two points passes through LOAD without a strobe
  // and is rejected there, so done follows start by two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_step      <= '0;
      r_npts      <= '0;
      r_idx       <= '0;
      r_prev      <= '0;
      r_dac_code  <= '0;
      r_dac_load  <= 1'b0;
      r_adc_req   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc   <= {1'b0, cfg_start};
            r_step  <= cfg_step;
            r_npts  <= cfg_npts;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
            if (cfg_npts >= DAC_W'(2)) begin
              r_dac_load <= 1'b1;
              r_dac_code <= cfg_start;
            end
          end
        end

        ST_LOAD: begin
          r_dac_load <= 1'b0;
          if (r_acc[DAC_W] || (r_npts < DAC_W'(2))) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (w_settle_exp) begin
            r_adc_req <= 1'b1;
            r_state   <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          if (r_adc_req && adc_valid) begin
            r_adc_req <= 1'b0;
            r_prev    <= adc_data;
            if (r_idx == '0) begin
              // First point only provides the reference sample
              r_idx      <= DAC_W'(1);
              r_acc      <= w_acc_next;
              r_dac_load <= ~w_ovf;
              if (!w_ovf) r_dac_code <= w_acc_next[DAC_W-1:0];
              r_state    <= ST_LOAD;
            end else begin
              r_res_data  <= w_delta;
              r_res_idx   <= r_idx;
              r_res_valid <= 1'b1;
              r_state     <= ST_EMIT;
            end
          end
        end

        ST_EMIT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_idx       <= w_idx_p1[DAC_W-1:0];
            if (w_idx_p1 == {1'b0, r_npts}) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_acc      <= w_acc_next;
              r_dac_load <= ~w_ovf;
              if (!w_ovf) r_dac_code <= w_acc_next[DAC_W-1:0];
              r_state    <= ST_LOAD;
            end
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dac_code  = r_dac_code;
  assign dac_load  = r_dac_load;
  assign adc_req   = r_adc_req;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_idx   = r_res_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_opv_gain_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_opv_gain_sweep_ctrl
// Description : Directed self-checking bench for opv_gain_sweep_ctrl with a
//               fixed-latency ADC responder and output monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opv_gain_sweep_ctrl;
  import opv_meas_pkg::*;

  localparam int c_ADC_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  cfg_start, cfg_step, cfg_npts;
  logic [7:0]  dac_code;
  logic        dac_load, adc_req, adc_valid;
  logic [11:0] adc_data;
  logic        res_valid, res_ready;
  logic [12:0] res_data;
  logic [7:0]  res_idx;
  logic        busy, done, err;

  opv_gain_sweep_ctrl #(
    .DAC_W      (8),
    .ADC_W      (12),
    .SETTLE_CYC (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_start (cfg_start),
    .cfg_step  (cfg_step),
    .cfg_npts  (cfg_npts),
    .dac_code  (dac_code),
    .dac_load  (dac_load),
    .adc_req   (adc_req),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_asserts = 0;
  int n_fails   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitors (sample on the falling edge) ----------------
  logic [7:0]  load_q[$];
  int          load_cyc[$];
  int          req_rise[$];
  int          req_fall[$];
  int          rv_rise[$];
  opv_result_t res_q[$];
  opv_result_t r_mon;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        req_d = 1'b0;
  logic        rv_d  = 1'b0;

  always @(negedge clk) begin
    if (dac_load) begin
      load_q.push_back(dac_code);
      load_cyc.push_back(cyc);
    end
    if (adc_req && !req_d) req_rise.push_back(cyc);
    if (!adc_req && req_d) req_fall.push_back(cyc);
    if (res_valid && !rv_d) rv_rise.push_back(cyc);
    if (res_valid && res_ready) begin
      r_mon.idx   = res_idx;
      r_mon.delta = res_data;
      res_q.push_back(r_mon);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    req_d <= adc_req;
    rv_d  <= res_valid;
  end

  // ---------------- ADC responder: valid c_ADC_LAT cycles after req -------
  logic [11:0] adc_vals[$];

  initial begin : adc_model
    adc_valid = 1'b0;
    adc_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (adc_req === 1'b1) begin
        repeat (c_ADC_LAT) begin @(posedge clk); #1; end
        adc_data  = (adc_vals.size() > 0) ? adc_vals.pop_front() : 12'h000;
        adc_valid = 1'b1;
        @(posedge clk); #1;
        adc_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input logic [7:0] s, input logic [7:0] st, input logic [7:0] n,
                          output int cs);
    @(posedge clk); #1;
    cfg_start = s; cfg_step = st; cfg_npts = n; start = 1'b1;
    cs = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, (done_cnt != d0), 1'b1);
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int nl, nr, nd, nq, nv, cs, k;
    logic [12:0] d0;
    logic [7:0]  i0;
    logic        stable_ok;
    logic [7:0]  exp_code[4];
    logic [7:0]  exp_idx[3];
    logic [12:0] exp_dlt[3];

    rst_n = 1'b0; start = 1'b0; res_ready = 1'b1;
    cfg_start = '0; cfg_step = '0; cfg_npts = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {26'd0, dac_load, adc_req, res_valid, busy, done, err}, 32'd0);
    check("rst_code_idx", {16'd0, dac_code, res_idx}, 32'd0);
    check("rst_res_data", {19'd0, res_data}, 32'd0);
    rst_n = 1'b1;

    // ---- 1: nominal sweep plus handshake timing ----
    nl = load_q.size(); nr = res_q.size(); nd = done_cnt;
    nq = req_rise.size(); nv = rv_rise.size();
    adc_vals.delete();
    adc_vals.push_back(12'd100); adc_vals.push_back(12'd150);
    adc_vals.push_back(12'd140); adc_vals.push_back(12'd4095);
    do_start(8'd5, 8'd10, 8'd4, cs);
    check("t1_busy", busy, 1'b1);
    wait_done("t1_done_seen", 400);
    exp_code = '{8'd5, 8'd15, 8'd25, 8'd35};
    exp_idx  = '{8'd1, 8'd2, 8'd3};
    exp_dlt  = '{13'h0032, 13'h1FF6, 13'h0F73};
    check("t1_nload", load_q.size() - nl, 4);
    if (load_q.size() - nl == 4)
      for (int i = 0; i < 4; i++) check("t1_code", load_q[nl+i], exp_code[i]);
    check("t1_nres", res_q.size() - nr, 3);
    if (res_q.size() - nr == 3)
      for (int i = 0; i < 3; i++) begin
        check("t1_res_idx", res_q[nr+i].idx, exp_idx[i]);
        check("t1_res_delta", res_q[nr+i].delta, exp_dlt[i]);
      end
    check("t1_ndone", done_cnt - nd, 1);
    check("t1_err", err, 1'b0);
    check("t1_busy_idle", busy, 1'b0);
    if (load_q.size() - nl >= 2 && req_rise.size() > nq && req_fall.size() > nq &&
        rv_rise.size() > nv) begin
      check("t1_req_after_load", req_rise[nq] - load_cyc[nl], 17);
      check("t1_req_width", req_fall[nq] - req_rise[nq], c_ADC_LAT + 1);
      check("t1_load_spacing", load_cyc[nl+1] - load_cyc[nl], 21);
      check("t1_result_latency", rv_rise[nv] - load_cyc[nl], 42);
    end else begin
      check("t1_timing_events", 0, 1);
    end

    // ---- 2: result back-pressure ----
    nl = load_q.size(); nr = res_q.size();
    adc_vals.delete();
    adc_vals.push_back(12'd500); adc_vals.push_back(12'd700); adc_vals.push_back(12'd600);
    res_ready = 1'b0;
    do_start(8'd20, 8'd4, 8'd3, cs);
    k = 0;
    while (!res_valid && k < 300) begin @(negedge clk); k++; end
    check("t2_res_valid_seen", res_valid, 1'b1);
    @(negedge clk);
    d0 = res_data; i0 = res_idx; stable_ok = 1'b1; k = load_q.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!res_valid || res_data !== d0 || res_idx !== i0) stable_ok = 1'b0;
    end
    check("t2_stable", stable_ok, 1'b1);
    check("t2_no_load_stall", load_q.size() - k, 0);
    check("t2_held_data", d0, 13'h00C8);
    check("t2_held_idx", i0, 8'd1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_done("t2_done_seen", 300);
    check("t2_nload", load_q.size() - nl, 3);
    check("t2_nres", res_q.size() - nr, 2);
    if (res_q.size() - nr == 2) check("t2_res2_delta", res_q[nr+1].delta, 13'h1F9C);

    // ---- 3: DAC code overflow ----
    nl = load_q.size(); nr = res_q.size(); nd = done_cnt;
    adc_vals.delete();
    adc_vals.push_back(12'd10); adc_vals.push_back(12'd20); adc_vals.push_back(12'd30);
    do_start(8'd250, 8'd3, 8'd4, cs);
    wait_done("t3_done_seen", 300);
    check("t3_nload", load_q.size() - nl, 2);
    if (load_q.size() - nl == 2) begin
      check("t3_code0", load_q[nl], 8'd250);
      check("t3_code1", load_q[nl+1], 8'd253);
    end
    check("t3_nres", res_q.size() - nr, 1);
    if (res_q.size() - nr == 1) begin
      check("t3_res_idx", res_q[nr].idx, 8'd1);
      check("t3_res_delta", res_q[nr].delta, 13'h000A);
    end
    check("t3_err", err, 1'b1);
    check("t3_dac_code_held", dac_code, 8'd253);
    check("t3_ndone", done_cnt - nd, 1);

    // ---- 4: too few points, then recovery ----
    nl = load_q.size(); nr = res_q.size(); nd = done_cnt;
    do_start(8'd9, 8'd1, 8'd1, cs);
    wait_done("t4_done_seen", 20);
    check("t4_done_latency", done_cyc - cs, 2);
    check("t4_err", err, 1'b1);
    check("t4_nload", load_q.size() - nl, 0);
    check("t4_nres", res_q.size() - nr, 0);
    check("t4_ndone", done_cnt - nd, 1);
    nl = load_q.size(); nr = res_q.size();
    adc_vals.delete();
    adc_vals.push_back(12'd300); adc_vals.push_back(12'd200);
    do_start(8'd0, 8'd5, 8'd2, cs);
    check("t4b_err_cleared", err, 1'b0);
    wait_done("t4b_done_seen", 200);
    check("t4b_nload", load_q.size() - nl, 2);
    check("t4b_nres", res_q.size() - nr, 1);
    if (res_q.size() - nr == 1) check("t4b_res_delta", res_q[nr].delta, 13'h1F9C);
    check("t4b_err", err, 1'b0);

    // ---- 5: asynchronous abort, then fresh sweep ignoring busy starts ----
    nl = load_q.size(); nd = done_cnt;
    adc_vals.delete();
    adc_vals.push_back(12'd1000); adc_vals.push_back(12'd1100);
    adc_vals.push_back(12'd1200); adc_vals.push_back(12'd1300);
    do_start(8'd0, 8'd1, 8'd4, cs);
    k = 0;
    while (load_q.size() - nl < 2 && k < 200) begin @(negedge clk); k++; end
    check("t5_second_load_seen", load_q.size() - nl, 2);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_abort_ctrl", {26'd0, dac_load, adc_req, res_valid, busy, done, err}, 32'd0);
    check("t5_abort_code_idx", {16'd0, dac_code, res_idx}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check("t5_no_done", done_cnt - nd, 0);
    nl = load_q.size(); nr = res_q.size(); nd = done_cnt;
    adc_vals.delete();
    adc_vals.push_back(12'd10); adc_vals.push_back(12'd30); adc_vals.push_back(12'd25);
    do_start(8'd7, 8'd2, 8'd3, cs);
    repeat (5) @(posedge clk);
    do_start(8'd100, 8'd50, 8'd2, cs);
    repeat (30) @(posedge clk);
    do_start(8'd100, 8'd50, 8'd2, cs);
    wait_done("t5_done_seen", 300);
    check("t5_nload", load_q.size() - nl, 3);
    if (load_q.size() - nl == 3) begin
      check("t5_code0", load_q[nl], 8'd7);
      check("t5_code2", load_q[nl+2], 8'd11);
    end
    check("t5_nres", res_q.size() - nr, 2);
    if (res_q.size() - nr == 2) begin
      check("t5_res1_delta", res_q[nr].delta, 13'h0014);
      check("t5_res2_delta", res_q[nr+1].delta, 13'h1FFB);
    end
    check("t5_ndone", done_cnt - nd, 1);
    check("t5_err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
